// File: rtl/layer_seq_pkg.sv
// Shared definitions for the conv layer pass sequencer: pass states and the
// default layer geometry that batch_ctrl is also built with.
package layer_seq_pkg;

    // Weight words per layer: kernel 25 x (oc / 2) 15.
    localparam int PRM_WORDS_DEF = 375;

    // Output beats per batch: oc 30 x sample 40 / 2.
    localparam int DST_WORDS_DEF = 600;

    // Width of the batch count.
    localparam int NB_W_DEF = 16;

    // One layer pass walks these states in order and returns to IDLE.
    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        RUN,
        DRAIN,
        FIN
    } seq_state_e;

    // Counter width able to hold 0 .. maxVal-1, never narrower than one bit.
    function automatic int cntWidth(input int maxVal);
        return (maxVal > 1) ? $clog2(maxVal) : 1;
    endfunction

endpackage

// File: rtl/layer_seq_beat_cnt.sv
// Wrapping beat counter: counts enabled beats from 0 to MAX-1 and flags the
// beat on which it rolls back to 0. A clear beats a simultaneous enable.
module beat_cnt #(
    parameter int W   = 9,
    parameter int MAX = 375
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         atLast;

    assign atLast = (cnt_q == LAST);
    assign wrap_o = en_i && !clr_i && atLast;
    assign cnt_o  = cnt_q;

    // Next count: clear first, otherwise step on enable and roll over at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = atLast ? '0 : cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/layer_seq.sv
// Top-level sequencer for one conv layer pass: weight load, nbatch sample
// batches with run held high, drain of the final outputs, then a done pulse.
module layer_seq
    import layer_seq_pkg::*;
#(
    parameter int PRM_WORDS = PRM_WORDS_DEF,
    parameter int DST_WORDS = DST_WORDS_DEF,
    parameter int NB_W      = NB_W_DEF
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [NB_W-1:0] nbatch_i,
    input  logic            src_valid_i,
    input  logic            src_ready_i,
    input  logic            s_init_i,
    input  logic            dst_valid_i,
    input  logic            dst_ready_i,
    output logic            matw_o,
    output logic            run_o,
    output logic            last_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [NB_W-1:0] bcnt_o
);

    localparam int WCNT_W = cntWidth(PRM_WORDS);
    localparam int DCNT_W = cntWidth(DST_WORDS);

    localparam logic [NB_W-1:0] NB_ZERO = '0;
    localparam logic [NB_W-1:0] NB_ONE  = NB_W'(1);

    seq_state_e      state_q;
    logic [NB_W-1:0] nb_q;
    logic [NB_W-1:0] icnt_q;
    logic [NB_W-1:0] bcnt_q;
    logic            matw_q;
    logic            run_q;
    logic            last_q;
    logic            busy_q;
    logic            done_q;

    logic              startAcc;
    logic              cntClr;
    logic              wEn;
    logic              dHs;
    logic              wWrap;
    logic              dWrap;
    logic [WCNT_W-1:0] wcnt;
    logic [DCNT_W-1:0] dcnt;

    // batch_ctrl takes weights without ready and the weight count position is
    // only needed for its wrap, so these bits are collected here on purpose.
    logic unusedBits;
    assign unusedBits = ^{src_ready_i, wcnt};

    assign startAcc = start_i && !abort_i && (state_q == IDLE);
    assign cntClr   = abort_i || startAcc;
    assign wEn      = (state_q == WLOAD) && src_valid_i;
    assign dHs      = ((state_q == RUN) || (state_q == DRAIN)) && dst_valid_i && dst_ready_i;

    beat_cnt #(
        .W   (WCNT_W),
        .MAX (PRM_WORDS)
    ) u_wcnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (wEn),
        .clr_i   (cntClr),
        .cnt_o   (wcnt),
        .wrap_o  (wWrap)
    );

    beat_cnt #(
        .W   (DCNT_W),
        .MAX (DST_WORDS)
    ) u_dcnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (dHs),
        .clr_i   (cntClr),
        .cnt_o   (dcnt),
        .wrap_o  (dWrap)
    );

    // Pass FSM with registered outputs plus the batch issue and drain counters.
    always_ff @(posedge clk_i) begin
        if (reset_i || abort_i) begin
            state_q <= IDLE;
            nb_q    <= '0;
            icnt_q  <= '0;
            bcnt_q  <= '0;
            matw_q  <= 1'b0;
            run_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        nb_q   <= nbatch_i;
                        icnt_q <= '0;
                        bcnt_q <= '0;
                        busy_q <= 1'b1;
                        if (nbatch_i == NB_ZERO) begin
                            state_q <= FIN;
                        end else begin
                            state_q <= WLOAD;
                            matw_q  <= 1'b1;
                        end
                    end
                end
                WLOAD: begin
                    if (wWrap) begin
                        matw_q  <= 1'b0;
                        run_q   <= 1'b1;
                        last_q  <= (nb_q == NB_ONE);
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (icnt_q == nb_q) begin
                        state_q <= DRAIN;
                    end else if (s_init_i) begin
                        icnt_q <= icnt_q + NB_ONE;
                        if ((icnt_q + NB_ONE) == (nb_q - NB_ONE)) begin
                            last_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if ((bcnt_q == nb_q) && (dcnt == '0)) begin
                        run_q   <= 1'b0;
                        last_q  <= 1'b0;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (dWrap && (bcnt_q != nb_q)) begin
                bcnt_q <= bcnt_q + NB_ONE;
            end
        end
    end

    assign matw_o = matw_q;
    assign run_o  = run_q;
    assign last_o = last_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcnt_o = bcnt_q;

endmodule
